// File: rtl/i2c_reg_target.sv
// I2C target: fixed 7-bit address, pointer byte, then auto-incrementing register read/write.
// Inputs lag the pins by sync+filter; SDA changes 1 clk after filtered SCL fall; no clock stretching.
module i2c_reg_target #(
  parameter logic [6:0] DEV_ADDR       = 7'h4D,
  parameter int         REG_ADDR_WIDTH = 4,
  parameter int         FILTER_LEN     = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      scl_i,
  input  logic                      sda_i,
  output logic                      sda_o,
  output logic                      sda_t,
  output logic                      busy,
  output logic                      bus_active,
  output logic                      wr_strobe,
  output logic [REG_ADDR_WIDTH-1:0] wr_addr,
  output logic [7:0]                wr_data,
  input  logic [REG_ADDR_WIDTH-1:0] host_addr,
  input  logic                      host_we,
  input  logic [7:0]                host_wdata,
  output logic [7:0]                host_rdata
);
  localparam int NREGS = 1 << REG_ADDR_WIDTH;
  localparam logic [REG_ADDR_WIDTH-1:0] PTR_ONE = REG_ADDR_WIDTH'(1);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK
  } state_t;

  state_t state, state_nxt;

  logic [1:0]            scl_sync, sda_sync;
  logic [FILTER_LEN-1:0] scl_hist, sda_hist;
  logic                  scl_f, sda_f, scl_d, sda_d;
  logic                  scl_rise, scl_fall, start_det, stop_det;

  logic [NREGS-1:0][7:0]     regs;
  logic [REG_ADDR_WIDTH-1:0] ptr;
  logic [7:0]                sh;
  logic [7:0]                rd_byte;
  logic [3:0]                cnt;
  logic                      ack_bit;
  logic                      rel_nxt, cnt_clr, ptr_go, wr_go, rd_go, tx_shift;
  logic                      busy_set, busy_clr, bit_state, rx_state;

  // A filtered line only flips after FILTER_LEN identical synchronized samples.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_hist <= '1;
      sda_hist <= '1;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
      scl_hist <= {scl_hist[FILTER_LEN-2:0], scl_sync[1]};
      sda_hist <= {sda_hist[FILTER_LEN-2:0], sda_sync[1]};
      if (&scl_hist) scl_f <= 1'b1;
      else if (~|scl_hist) scl_f <= 1'b0;
      if (&sda_hist) sda_f <= 1'b1;
      else if (~|sda_hist) sda_f <= 1'b0;
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  assign scl_rise  = scl_f & ~scl_d;
  assign scl_fall  = ~scl_f & scl_d;
  assign start_det = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;
  assign rd_byte   = regs[ptr];
  assign rx_state  = (state == ADDR) || (state == PTR) || (state == WDATA);
  assign bit_state = rx_state || (state == RDATA) || (state == RACK);
  assign sda_o     = sda_t;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Every bit-level transition happens on the filtered SCL falling edge.
  always_comb begin
    state_nxt = state;
    rel_nxt   = sda_t;
    cnt_clr   = 1'b0;
    ptr_go    = 1'b0;
    wr_go     = 1'b0;
    rd_go     = 1'b0;
    tx_shift  = 1'b0;
    busy_set  = 1'b0;
    busy_clr  = 1'b0;
    if (stop_det) begin
      state_nxt = IDLE;
      rel_nxt   = 1'b1;
      busy_clr  = 1'b1;
    end else if (start_det) begin
      state_nxt = ADDR;
      rel_nxt   = 1'b1;
      cnt_clr   = 1'b1;
    end else if (scl_fall) begin
      case (state)
        ADDR: if (cnt == 4'd8) begin
          if (sh[7:1] == DEV_ADDR) begin
            state_nxt = ADDR_ACK;
            rel_nxt   = 1'b0;
            busy_set  = 1'b1;
          end else begin
            state_nxt = IDLE;
            busy_clr  = 1'b1;
          end
        end
        ADDR_ACK: begin
          cnt_clr = 1'b1;
          if (sh[0]) begin
            state_nxt = RDATA;
            rd_go     = 1'b1;
            rel_nxt   = rd_byte[7];
          end else begin
            state_nxt = PTR;
            rel_nxt   = 1'b1;
          end
        end
        PTR: if (cnt == 4'd8) begin
          state_nxt = PTR_ACK;
          rel_nxt   = 1'b0;
          ptr_go    = 1'b1;
        end
        WDATA: if (cnt == 4'd8) begin
          state_nxt = WDATA_ACK;
          rel_nxt   = 1'b0;
          wr_go     = 1'b1;
        end
        PTR_ACK, WDATA_ACK: begin
          state_nxt = WDATA;
          rel_nxt   = 1'b1;
          cnt_clr   = 1'b1;
        end
        RDATA: if (cnt == 4'd8) begin
          state_nxt = RACK;
          rel_nxt   = 1'b1;
          cnt_clr   = 1'b1;
        end else if (cnt != 4'd0) begin
          rel_nxt  = sh[6];
          tx_shift = 1'b1;
        end
        RACK: if (cnt != 4'd0) begin
          if (!ack_bit) begin
            state_nxt = RDATA;
            rd_go     = 1'b1;
            rel_nxt   = rd_byte[7];
            cnt_clr   = 1'b1;
          end else begin
            state_nxt = IDLE;
            rel_nxt   = 1'b1;
            busy_clr  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sda_t      <= 1'b1;
      cnt        <= '0;
      sh         <= '0;
      ptr        <= '0;
      ack_bit    <= 1'b1;
      busy       <= 1'b0;
      bus_active <= 1'b0;
      wr_strobe  <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      host_rdata <= '0;
      regs       <= '0;
    end else begin
      sda_t     <= rel_nxt;
      wr_strobe <= wr_go;
      if (cnt_clr) cnt <= '0;
      else if (scl_rise && bit_state) cnt <= cnt + 4'd1;
      if (rd_go) sh <= rd_byte;
      else if (tx_shift) sh <= {sh[6:0], 1'b0};
      else if (scl_rise && rx_state) sh <= {sh[6:0], sda_f};
      if (scl_rise && state == RACK) ack_bit <= sda_f;
      if (ptr_go) ptr <= sh[REG_ADDR_WIDTH-1:0];
      else if (rd_go || wr_go) ptr <= ptr + PTR_ONE;
      if (wr_go) begin
        wr_addr <= ptr;
        wr_data <= sh;
      end
      if (busy_clr) busy <= 1'b0;
      else if (busy_set) busy <= 1'b1;
      if (stop_det) bus_active <= 1'b0;
      else if (start_det) bus_active <= 1'b1;
      // I2C write is issued last so it overrides a same-index host write.
      if (host_we) regs[host_addr] <= host_wdata;
      if (wr_go) regs[ptr] <= sh;
      host_rdata <= regs[host_addr];
    end
  end
endmodule

// File: tb/tb_i2c_reg_target.sv
// Directed bench for i2c_reg_target: host-port vector table plus bit-banged I2C sequences.
module tb_i2c_reg_target;
  localparam int Q = 100;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_o, sda_t, busy, bus_active, wr_strobe;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] host_addr = 4'd0;
  logic       host_we = 1'b0;
  logic [7:0] host_wdata = 8'd0;
  logic [7:0] host_rdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;
  assign sda_line = sda_m & (sda_t | sda_o);

  i2c_reg_target dut (
    .clk(clk), .rstn(rstn), .scl_i(scl_m), .sda_i(sda_line),
    .sda_o(sda_o), .sda_t(sda_t), .busy(busy), .bus_active(bus_active),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
    .host_addr(host_addr), .host_we(host_we), .host_wdata(host_wdata),
    .host_rdata(host_rdata)
  );

  // Strobe log and line monitors
  logic [11:0] stb_log [64];
  int stb_n = 0, stb_bad_width = 0, stb_no_ack = 0, sda_low_cnt = 0, busy_cnt = 0;
  logic stb_prev = 1'b0;
  always @(negedge clk) begin
    if (wr_strobe) begin
      stb_log[stb_n[5:0]] <= {wr_addr, wr_data};
      stb_n <= stb_n + 1;
      if (stb_prev) stb_bad_width <= stb_bad_width + 1;
      if (sda_t) stb_no_ack <= stb_no_ack + 1;
    end
    if (!sda_t) sda_low_cnt <= sda_low_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    stb_prev <= wr_strobe;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic i2c_bit(input logic b, output logic s);
    #Q sda_m = b;
    #Q scl_m = 1'b1;
    #Q s = sda_line;
    #Q scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    #Q sda_m = 1'b1;
    #Q scl_m = 1'b1;
    #Q sda_m = 1'b0;
    #Q scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    #Q sda_m = 1'b0;
    #Q scl_m = 1'b1;
    #Q sda_m = 1'b1;
    #Q;
  endtask

  task automatic send_chk(input string name, input logic [7:0] b, input logic exp_ack);
    logic s;
    for (int i = 7; i >= 0; i--) i2c_bit(b[i], s);
    i2c_bit(1'b1, s);
    check(name, 32'(s), 32'(exp_ack));
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    d = 8'd0;
    for (int i = 0; i < 8; i++) begin
      i2c_bit(1'b1, s);
      d = {d[6:0], s};
    end
    i2c_bit(nack, s);
  endtask

  int stb_rd = 0;
  task automatic expect_strobe(input string name, input logic [3:0] a, input logic [7:0] d);
    if (stb_rd >= stb_n) begin
      tests++;
      fails++;
      $display("FAIL %s: no wr_strobe seen, expected addr %0d data 0x%0h", name, a, d);
    end else begin
      check(name, 32'(stb_log[stb_rd[5:0]]), 32'({a, d}));
      stb_rd++;
    end
  endtask

  task automatic host_read(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    host_addr = a;
    host_we   = 1'b0;
    @(posedge clk);
    #1 d = host_rdata;
  endtask

  typedef struct {
    logic [3:0] addr;
    logic       we;
    logic [7:0] wdata;
    logic [7:0] exp;
  } hvec_t;

  hvec_t hv [9];

  initial begin
    logic [7:0] d;
    int lowc, bc;

    hv[0] = '{4'd5, 1'b0, 8'h00, 8'h00};
    hv[1] = '{4'd5, 1'b1, 8'hA5, 8'h00};
    hv[2] = '{4'd5, 1'b0, 8'h00, 8'hA5};
    hv[3] = '{4'd7, 1'b1, 8'h3C, 8'h00};
    hv[4] = '{4'd5, 1'b1, 8'h00, 8'hA5};
    hv[5] = '{4'd7, 1'b0, 8'h00, 8'h3C};
    hv[6] = '{4'd5, 1'b0, 8'h00, 8'h00};
    hv[7] = '{4'd2, 1'b1, 8'h77, 8'h00};
    hv[8] = '{4'd2, 1'b0, 8'h00, 8'h77};

    repeat (4) @(posedge clk);
    #1;
    check("rst_sda_t", 32'(sda_t), 32'd1);
    check("rst_sda_o", 32'(sda_o), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_bus_active", 32'(bus_active), 32'd0);
    check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_host_rdata", 32'(host_rdata), 32'd0);
    @(negedge clk) rstn = 1'b1;
    repeat (3) @(posedge clk);

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      host_addr  = hv[i].addr;
      host_we    = hv[i].we;
      host_wdata = hv[i].wdata;
      @(posedge clk);
      #1 check($sformatf("host_vec%0d", i), 32'(host_rdata), 32'(hv[i].exp));
    end
    @(negedge clk) host_we = 1'b0;

    // Write: ptr 3, data 5A C3
    i2c_start();
    send_chk("wr_ack_addr", 8'h9A, 1'b0);
    check("wr_busy", 32'(busy), 32'd1);
    check("wr_bus_active", 32'(bus_active), 32'd1);
    send_chk("wr_ack_ptr", 8'h03, 1'b0);
    send_chk("wr_ack_d0", 8'h5A, 1'b0);
    send_chk("wr_ack_d1", 8'hC3, 1'b0);
    i2c_stop();
    check("wr_busy_after_stop", 32'(busy), 32'd0);
    check("wr_bus_after_stop", 32'(bus_active), 32'd0);
    check("wr_sda_released", 32'(sda_t), 32'd1);
    expect_strobe("wr_strobe0", 4'd3, 8'h5A);
    expect_strobe("wr_strobe1", 4'd4, 8'hC3);
    check("wr_no_extra", 32'(stb_n - stb_rd), 32'd0);
    check("wr_addr_hold", 32'(wr_addr), 32'd4);
    check("wr_data_hold", 32'(wr_data), 32'hC3);
    host_read(4'd4, d);
    check("wr_host_rd4", 32'(d), 32'hC3);

    // Random read with repeated start
    i2c_start();
    send_chk("rr_ack_addr", 8'h9A, 1'b0);
    send_chk("rr_ack_ptr", 8'h03, 1'b0);
    i2c_start();
    send_chk("rr_ack_raddr", 8'h9B, 1'b0);
    read_byte(1'b0, d);
    check("rr_byte0", 32'(d), 32'h5A);
    read_byte(1'b1, d);
    check("rr_byte1", 32'(d), 32'hC3);
    #Q;
    check("rr_sda_released", 32'(sda_t), 32'd1);
    check("rr_busy_after_nack", 32'(busy), 32'd0);
    check("rr_bus_active", 32'(bus_active), 32'd1);
    i2c_stop();
    check("rr_no_strobe", 32'(stb_n - stb_rd), 32'd0);

    // Address mismatch
    lowc = sda_low_cnt;
    bc   = busy_cnt;
    i2c_start();
    send_chk("mm_nack_addr", 8'h9E, 1'b1);
    send_chk("mm_nack_byte", 8'h00, 1'b1);
    check("mm_bus_active", 32'(bus_active), 32'd1);
    i2c_stop();
    check("mm_bus_after_stop", 32'(bus_active), 32'd0);
    check("mm_sda_never_low", 32'(sda_low_cnt - lowc), 32'd0);
    check("mm_busy_never", 32'(busy_cnt - bc), 32'd0);
    check("mm_no_strobe", 32'(stb_n - stb_rd), 32'd0);

    // Pointer wrap 15 -> 0
    i2c_start();
    send_chk("wp_ack_addr", 8'h9A, 1'b0);
    send_chk("wp_ack_ptr", 8'h0F, 1'b0);
    send_chk("wp_ack_d0", 8'h11, 1'b0);
    send_chk("wp_ack_d1", 8'h22, 1'b0);
    i2c_stop();
    expect_strobe("wp_strobe0", 4'd15, 8'h11);
    expect_strobe("wp_strobe1", 4'd0, 8'h22);
    host_read(4'd15, d);
    check("wp_reg15", 32'(d), 32'h11);
    host_read(4'd0, d);
    check("wp_reg0", 32'(d), 32'h22);

    // Abort a partial data byte with Sr, then read from the unchanged pointer
    i2c_start();
    send_chk("ab_ack_addr", 8'h9A, 1'b0);
    send_chk("ab_ack_ptr", 8'h02, 1'b0);
    for (int i = 0; i < 5; i++) begin
      logic s;
      i2c_bit(~i[0], s);
    end
    i2c_start();
    send_chk("ab_ack_raddr", 8'h9B, 1'b0);
    read_byte(1'b1, d);
    check("ab_read", 32'(d), 32'h77);
    i2c_stop();
    check("ab_no_strobe", 32'(stb_n - stb_rd), 32'd0);
    host_read(4'd2, d);
    check("ab_reg2", 32'(d), 32'h77);

    // Reset while driving a 0 read bit (regs[0] = 0x22, MSB is 0)
    i2c_start();
    send_chk("rs_ack_addr", 8'h9A, 1'b0);
    send_chk("rs_ack_ptr", 8'h00, 1'b0);
    i2c_start();
    send_chk("rs_ack_raddr", 8'h9B, 1'b0);
    #Q;
    check("rs_driving_zero", 32'(sda_t), 32'd0);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("rs_async_release", 32'(sda_t), 32'd1);
    check("rs_busy", 32'(busy), 32'd0);
    sda_m = 1'b1;
    #Q scl_m = 1'b1;
    #Q;
    @(negedge clk) rstn = 1'b1;
    #Q;
    i2c_start();
    send_chk("rs2_ack_addr", 8'h9A, 1'b0);
    send_chk("rs2_ack_ptr", 8'h08, 1'b0);
    send_chk("rs2_ack_d0", 8'hE7, 1'b0);
    i2c_stop();
    expect_strobe("rs2_strobe", 4'd8, 8'hE7);
    host_read(4'd8, d);
    check("rs2_reg8", 32'(d), 32'hE7);
    host_read(4'd0, d);
    check("rs2_reg0_cleared", 32'(d), 32'h00);

    check("strobe_width", 32'(stb_bad_width), 32'd0);
    check("strobe_with_ack", 32'(stb_no_ack), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
